// File: rtl/game_pkg.sv
// Shared types and keycodes for the game phase controller and its key event generator.
package game_pkg;

  typedef enum logic [2:0] {
    PH_TITLE = 3'd0,
    PH_PLAY  = 3'd1,
    PH_PAUSE = 3'd2,
    PH_WIN   = 3'd3,
    PH_LOSE  = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_ESC   = 8'h29;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_D     = 8'h07;

  localparam int RPT_CNT_W = 6;
  localparam int END_CNT_W = 7;

  function automatic logic is_move_key(input logic [7:0] kc);
    return (kc == KC_W) || (kc == KC_A) || (kc == KC_S) || (kc == KC_D);
  endfunction

  function automatic logic is_known_key(input logic [7:0] kc);
    return is_move_key(kc) || (kc == KC_ENTER) || (kc == KC_ESC);
  endfunction

  function automatic dir_t key_to_dir(input logic [7:0] kc);
    dir_t d;
    case (kc)
      KC_A:    d = DIR_LEFT;
      KC_S:    d = DIR_DOWN;
      KC_D:    d = DIR_RIGHT;
      default: d = DIR_UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_event_gen.sv
// Turns the level-held keycode into registered one-cycle press/repeat events.
module key_event_gen
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  output logic       evt,
  output logic [7:0] evt_code,
  output logic       evt_is_repeat
);

  localparam logic [RPT_CNT_W-1:0] DELAY_LD = RPT_CNT_W'(REPEAT_DELAY);
  localparam logic [RPT_CNT_W-1:0] RATE_LD  = RPT_CNT_W'(REPEAT_RATE);

  logic [7:0]           key_q;
  logic [RPT_CNT_W-1:0] rpt_cnt;
  logic [RPT_CNT_W-1:0] rpt_nxt;
  logic                 press;
  logic                 held;
  logic                 rpt_fire;

  always_comb begin
    press    = (keycode != 8'h00) && (keycode != key_q);
    held     = (keycode != 8'h00) && (keycode == key_q);
    rpt_fire = held && frame_tick && (rpt_cnt == RPT_CNT_W'(1));
    rpt_nxt  = rpt_cnt;
    if (keycode == 8'h00) begin
      rpt_nxt = '0;
    end else if (press) begin
      // a press wins over a coincident frame_tick; only movement keys arm the counter
      rpt_nxt = is_move_key(keycode) ? DELAY_LD : '0;
    end else if (held && frame_tick) begin
      if (rpt_cnt == RPT_CNT_W'(1)) begin
        rpt_nxt = RATE_LD;
      end else if (rpt_cnt != '0) begin
        rpt_nxt = rpt_cnt - RPT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    key_q <= keycode;
    if (Reset) begin
      rpt_cnt       <= '0;
      evt           <= 1'b0;
      evt_code      <= 8'h00;
      evt_is_repeat <= 1'b0;
    end else begin
      rpt_cnt       <= rpt_nxt;
      evt           <= (press && is_known_key(keycode)) || rpt_fire;
      evt_code      <= keycode;
      evt_is_repeat <= rpt_fire;
    end
  end

endmodule

// File: rtl/game_phase_controller.sv
// Game phase sequencer: title/play/pause/win/lose FSM with gated movement commands.
//   state    | meaning
//   PH_TITLE | waiting for Enter to start a new game
//   PH_PLAY  | game running, movement commands forwarded
//   PH_PAUSE | frozen; Esc or Enter resumes
//   PH_WIN   | goal reached; Enter returns to title after END_HOLD ticks
//   PH_LOSE  | player died; Enter returns to title after END_HOLD ticks
module game_phase_controller
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6,
  parameter int END_HOLD     = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic       player_dead,
  input  logic       goal_reached,
  output logic [2:0] phase,
  output logic       play_en,
  output logic       new_game,
  output logic       move_valid,
  output logic [1:0] move_dir
);

  localparam logic [END_CNT_W-1:0] END_LD = END_CNT_W'(END_HOLD);

  logic                 evt;
  logic [7:0]           evt_code;
  logic                 evt_is_repeat;

  phase_t               phase_q;
  phase_t               phase_nxt;
  logic [END_CNT_W-1:0] end_cnt;
  logic [END_CNT_W-1:0] end_nxt;
  logic                 play_en_q;
  logic                 new_game_q;
  logic                 new_game_nxt;
  logic                 mv_q;
  logic                 mv_nxt;
  dir_t                 dir_q;
  dir_t                 dir_nxt;
  logic                 enter_p;
  logic                 esc_p;
  logic                 move_e;

  key_event_gen #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_key_event_gen (
    .Clk           (Clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .frame_tick    (frame_tick),
    .evt           (evt),
    .evt_code      (evt_code),
    .evt_is_repeat (evt_is_repeat)
  );

  always_comb begin
    enter_p      = evt && !evt_is_repeat && (evt_code == KC_ENTER);
    esc_p        = evt && !evt_is_repeat && (evt_code == KC_ESC);
    move_e       = evt && is_move_key(evt_code);
    phase_nxt    = phase_q;
    end_nxt      = end_cnt;
    new_game_nxt = 1'b0;
    mv_nxt       = 1'b0;
    dir_nxt      = dir_q;

    case (phase_q)
      PH_TITLE: begin
        if (enter_p) begin
          phase_nxt    = PH_PLAY;
          new_game_nxt = 1'b1;
        end
      end
      PH_PLAY: begin
        // a move coinciding with a phase exit is dropped
        if (player_dead) begin
          phase_nxt = PH_LOSE;
        end else if (goal_reached) begin
          phase_nxt = PH_WIN;
        end else if (esc_p) begin
          phase_nxt = PH_PAUSE;
        end else if (move_e) begin
          mv_nxt  = 1'b1;
          dir_nxt = key_to_dir(evt_code);
        end
      end
      PH_PAUSE: begin
        if (esc_p || enter_p) begin
          phase_nxt = PH_PLAY;
        end
      end
      PH_WIN, PH_LOSE: begin
        if (frame_tick && (end_cnt != '0)) begin
          end_nxt = end_cnt - END_CNT_W'(1);
        end
        if (enter_p && (end_cnt == '0)) begin
          phase_nxt = PH_TITLE;
        end
      end
      default: begin
        phase_nxt = PH_TITLE;
      end
    endcase

    if ((phase_q == PH_PLAY) && ((phase_nxt == PH_WIN) || (phase_nxt == PH_LOSE))) begin
      end_nxt = END_LD;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase_q    <= PH_TITLE;
      end_cnt    <= '0;
      play_en_q  <= 1'b0;
      new_game_q <= 1'b0;
      mv_q       <= 1'b0;
      dir_q      <= DIR_UP;
    end else begin
      phase_q    <= phase_nxt;
      end_cnt    <= end_nxt;
      play_en_q  <= (phase_nxt == PH_PLAY);
      new_game_q <= new_game_nxt;
      mv_q       <= mv_nxt;
      dir_q      <= dir_nxt;
    end
  end

  assign phase      = phase_q;
  assign play_en    = play_en_q;
  assign new_game   = new_game_q;
  assign move_valid = mv_q;
  assign move_dir   = dir_q;

endmodule

// File: tb/tb_game_phase_controller.sv
// Directed vector bench for game_phase_controller with small repeat/end-hold parameters.
module tb_game_phase_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       player_dead;
  logic       goal_reached;
  logic [2:0] phase;
  logic       play_en;
  logic       new_game;
  logic       move_valid;
  logic [1:0] move_dir;

  int n_chk = 0;
  int n_bad = 0;

  game_phase_controller #(
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2),
    .END_HOLD     (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .frame_tick   (frame_tick),
    .player_dead  (player_dead),
    .goal_reached (goal_reached),
    .phase        (phase),
    .play_en      (play_en),
    .new_game     (new_game),
    .move_valid   (move_valid),
    .move_dir     (move_dir)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rst;
    logic [7:0] kc;
    logic       tk;
    logic       dead;
    logic       goal;
    logic [2:0] ph;
    logic       ng;
    logic       mv;
    logic [1:0] dir;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [7:0] kc, input logic tk, input logic dead,
                     input logic goal, input logic [2:0] ph, input logic ng, input logic mv,
                     input logic [1:0] dir);
    vec_t v;
    v.rst = rst; v.kc = kc; v.tk = tk; v.dead = dead; v.goal = goal;
    v.ph = ph; v.ng = ng; v.mv = mv; v.dir = dir;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] kc, input logic tk,
                       input logic dead, input logic goal);
    Reset = rst; keycode = kc; frame_tick = tk; player_dead = dead; goal_reached = goal;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  logic [8:0] strobes;
  logic [8:0] strobes_exp;
  int         waited;

  initial begin
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    // reset, then Enter starts a game
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);   // r0
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h28, 0, 0, 0, 0, 0, 0, 0);   // r3 press
    add(0, 8'h28, 0, 0, 0, 1, 1, 0, 0);
    add(0, 8'h28, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    // hold D: press strobe, then repeats after ticks 3, 5, 7
    add(0, 8'h07, 0, 0, 0, 1, 0, 0, 0);   // r8 press
    add(0, 8'h07, 0, 0, 0, 1, 0, 1, 3);
    add(0, 8'h07, 1, 0, 0, 1, 0, 0, 0);   // tick1
    add(0, 8'h07, 1, 0, 0, 1, 0, 0, 0);   // tick2
    add(0, 8'h07, 1, 0, 0, 1, 0, 0, 0);   // tick3
    add(0, 8'h07, 0, 0, 0, 1, 0, 1, 3);
    add(0, 8'h07, 1, 0, 0, 1, 0, 0, 0);   // tick4
    add(0, 8'h07, 1, 0, 0, 1, 0, 0, 0);   // tick5
    add(0, 8'h07, 0, 0, 0, 1, 0, 1, 3);
    add(0, 8'h07, 1, 0, 0, 1, 0, 0, 0);   // tick6
    add(0, 8'h07, 1, 0, 0, 1, 0, 0, 0);   // tick7
    add(0, 8'h00, 0, 0, 0, 1, 0, 1, 3);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);   // r20
    // A then directly D
    add(0, 8'h04, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h07, 0, 0, 0, 1, 0, 1, 1);
    add(0, 8'h00, 0, 0, 0, 1, 0, 1, 3);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    // pause: W and dead/goal ignored, Esc resumes, W moves
    add(0, 8'h29, 0, 0, 0, 1, 0, 0, 0);   // r25
    add(0, 8'h00, 0, 0, 0, 2, 0, 0, 0);
    add(0, 8'h1A, 0, 0, 0, 2, 0, 0, 0);
    add(0, 8'h00, 0, 1, 1, 2, 0, 0, 0);
    add(0, 8'h29, 0, 0, 0, 2, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);   // r30
    add(0, 8'h1A, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 1, 0);
    // dead + goal + Esc together -> LOSE next cycle
    add(0, 8'h29, 0, 1, 1, 4, 0, 0, 0);   // r33
    add(0, 8'h00, 0, 0, 0, 4, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 4, 0, 0, 0);   // end_cnt 3
    add(0, 8'h00, 1, 0, 0, 4, 0, 0, 0);   // end_cnt 2
    add(0, 8'h28, 0, 0, 0, 4, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 4, 0, 0, 0);   // early Enter discarded
    add(0, 8'h00, 1, 0, 0, 4, 0, 0, 0);   // end_cnt 1
    add(0, 8'h00, 1, 0, 0, 4, 0, 0, 0);   // r40 end_cnt 0
    add(0, 8'h28, 1, 0, 0, 4, 0, 0, 0);   // saturates at 0
    add(0, 8'h28, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h28, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // new game, A press dropped by coincident goal -> WIN
    add(0, 8'h28, 0, 0, 0, 0, 0, 0, 0);   // r45
    add(0, 8'h04, 0, 0, 0, 1, 1, 0, 0);
    add(0, 8'h04, 0, 0, 1, 3, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3, 0, 0, 0);
    // Reset mid-game with Enter held across it
    add(1, 8'h28, 0, 0, 0, 0, 0, 0, 0);   // r49
    add(1, 8'h28, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h28, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h28, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h28, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 0);   // r55
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].kc, tbl[i].tk, tbl[i].dead, tbl[i].goal);
      cyc();
      chk($sformatf("row%0d phase", i), {5'd0, phase}, {5'd0, tbl[i].ph});
      chk($sformatf("row%0d play_en", i), {7'd0, play_en}, {7'd0, (tbl[i].ph == 3'd1)});
      chk($sformatf("row%0d new_game", i), {7'd0, new_game}, {7'd0, tbl[i].ng});
      chk($sformatf("row%0d move_valid", i), {7'd0, move_valid}, {7'd0, tbl[i].mv});
      if (tbl[i].mv)
        chk($sformatf("row%0d move_dir", i), {6'd0, move_dir}, {6'd0, tbl[i].dir});
    end

    // S held with a tick on every cycle, including the press cycle
    strobes     = '0;
    strobes_exp = 9'b1_0101_0010;
    for (int p = 0; p < 9; p++) begin
      drive(1'b0, 8'h16, 1'b1, 1'b0, 1'b0);
      cyc();
      strobes[p] = move_valid;
      if (p == 1)
        chk("s_press move_dir", {6'd0, move_dir}, 8'd2);
    end
    chk("s_repeat strobes_lo", strobes[7:0], strobes_exp[7:0]);
    chk("s_repeat strobes_hi", {7'd0, strobes[8]}, {7'd0, strobes_exp[8]});

    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();

    // Esc to pause, bounded wait
    drive(1'b0, 8'h29, 1'b0, 1'b0, 1'b0);
    cyc();
    waited = 1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    while ((phase !== 3'd2) && (waited < 10)) begin
      cyc();
      waited++;
    end
    chk("esc_pause reached", {5'd0, phase}, 8'd2);
    chk("esc_pause latency", 8'(waited), 8'd2);
    chk("esc_pause play_en", {7'd0, play_en}, 8'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/game_phase_controller.md
# game_phase_controller

Top-level game sequencer between the USB keyboard keycode register and the game datapath. It turns the raw, level-held 8-bit keycode into one-cycle key events, with auto-repeat for movement keys. It sequences the game through title, play, pause, win and lose phases, and it gates movement commands to the player-motion logic so they reach it only while play is active.

## Interface
Parameters:
- REPEAT_DELAY, 20: frame ticks a movement key is held before the first auto-repeat event.
- REPEAT_RATE, 6: frame ticks between subsequent auto-repeat events.
- END_HOLD, 60: frame ticks the WIN/LOSE screen ignores Enter.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  current USB keycode; 0 = no key; held while pressed.
- frame_tick  in  1  one-Clk pulse per video frame (vsync-derived).
- player_dead  in  1  level, from collision logic.
- goal_reached  in  1  level, from map logic.
- phase  out  3  current phase_t encoding.
- play_en  out  1  high iff phase == PLAY.
- new_game  out  1  one-cycle pulse; clears score and positions.
- move_valid  out  1  one-cycle movement command strobe.
- move_dir  out  2  0 = up (W), 1 = left (A), 2 = down (S), 3 = right (D); valid with move_valid.

## Operation
- Keycodes: ENTER 8'h28, ESC 8'h29, W 8'h1A, A 8'h04, S 8'h16, D 8'h07. All other nonzero codes are ignored: they produce no event, but they do count as "key held" for edge detection.
- Press event: keycode != 0 and keycode != key_q, where key_q is the previous-cycle keycode. A direct change from one key to another (A to D) is a new press.
- Auto-repeat, W/A/S/D only:
  - A press loads rpt_cnt = REPEAT_DELAY.
  - While keycode == key_q != 0, each frame_tick decrements rpt_cnt.
  - A tick that finds rpt_cnt == 1 emits a repeat event and reloads REPEAT_RATE.
  - Release (keycode == 0) zeroes rpt_cnt.
- Enter and ESC never repeat.
- Phases, in phase_t order: TITLE = 0, PLAY = 1, PAUSE = 2, WIN = 3, LOSE = 4.
  - TITLE: Enter press → PLAY, and pulse new_game.
  - PLAY:
    - player_dead → LOSE.
    - Otherwise goal_reached → WIN.
    - Otherwise ESC press → PAUSE.
    - Priority is dead > goal > ESC.
    - A W/A/S/D press or repeat event → move_valid plus move_dir.
  - PAUSE: ESC or Enter press → PLAY. The dead/goal inputs are ignored in this phase.
  - WIN/LOSE:
    - On entry, end_cnt = END_HOLD; it decrements on each frame_tick down to 0.
    - An Enter press when end_cnt == 0 → TITLE.
    - An Enter press earlier is discarded.
- move_valid is never asserted outside PLAY. A move event arriving in the same cycle as a PLAY exit is dropped.
- Reset:
  - phase = TITLE; play_en = 0; new_game = 0; move_valid = 0; move_dir = 0; rpt_cnt = 0; end_cnt = 0.
  - key_q tracks keycode during reset, so a key held across reset produces no event.
  - A reset asserted mid-game overrides every other input in that cycle.

## Timing
- Cycle N: keycode first differs from key_q. The key event register is high in cycle N+1 only.
- Cycle N+2:
  - Phase change, play_en, new_game and move_valid/move_dir all become visible; every output is registered.
  - new_game is high during the first PLAY cycle only.
- Repeat event: registered in the cycle after the qualifying frame_tick. The command appears 2 cycles after that tick.
- player_dead/goal_reached asserted in cycle M: the phase changes at M+1.
- frame_tick coinciding with a new press: the load takes precedence and no decrement occurs.
- end_cnt saturates at 0.
- rpt_cnt is 6 bits and end_cnt is 7 bits. Parameters must fit these widths.

## Structure
- game_pkg holds:
  - phase_t (enum logic [2:0]);
  - dir_t;
  - keycode localparams KC_ENTER, KC_ESC, KC_W, KC_A, KC_S, KC_D.
- Sub-module key_event_gen contains key_q, the press compare and the repeat counter. Its outputs are evt (1 bit), evt_code (8 bits) and evt_is_repeat.
- The top level contains the phase FSM, end_cnt and the output registers.

## Test plan
- Reset, then keycode = 8'h28 for 3 cycles from cycle 10 → new_game = 1 and phase = PLAY at cycle 12 only; no second event while the key stays held.
- In PLAY, hold 8'h07 with REPEAT_DELAY = 3 and REPEAT_RATE = 2 → move_dir = 3 strobes at press+2, then 2 cycles after ticks 3, 5 and 7.
- In PLAY, player_dead and goal_reached rise together with an ESC press → phase = LOSE.
- In LOSE with END_HOLD = 4: Enter after 2 ticks → stays LOSE; Enter after 4 ticks → TITLE.
- In PAUSE, press W → move_valid stays 0; press ESC → PLAY; a W press afterwards gives move_dir = 0.
- Hold Enter across a Reset pulse → phase stays TITLE and new_game stays 0. Release then re-press → PLAY.
